// File: rtl/snake_engine_if.sv
// Signal bundle between the snake game core and the controller/renderer that drives it.
interface snake_engine_if #(
    parameter int X_BITS   = 5,
    parameter int Y_BITS   = 5,
    parameter int LEN_BITS = 5
) ();
    // No valid/ready pair: buttons are levels, tick is a one-cycle strobe, and a cell
    // presented on q_x/q_y is always answered on q_* in the next cycle, with no back-pressure.
    logic                up;
    logic                down;
    logic                left;
    logic                right;
    logic                tick;
    logic [X_BITS-1:0]   q_x;
    logic [Y_BITS-1:0]   q_y;
    logic                q_head;
    logic                q_body;
    logic                q_food;
    logic [X_BITS-1:0]   head_x;
    logic [Y_BITS-1:0]   head_y;
    logic [LEN_BITS-1:0] length;
    logic [7:0]          score;
    logic                game_over;
    logic [1:0]          dbg_state;

    modport master (
        output up, down, left, right, tick, q_x, q_y,
        input  q_head, q_body, q_food, head_x, head_y, length, score, game_over, dbg_state
    );

    modport slave (
        input  up, down, left, right, tick, q_x, q_y,
        output q_head, q_body, q_food, head_x, head_y, length, score, game_over, dbg_state
    );
endinterface

// File: rtl/snake_engine.sv
// Snake game core: body, food and game state on a GRID_W x GRID_H grid with a 1-cycle cell query port.
// Define SNAKE_WRAP_EN to make the grid edges wrap around instead of ending the game.
module snake_engine #(
    parameter int          GRID_W    = 32,
    parameter int          GRID_H    = 24,
    parameter int          X_BITS    = 5,
    parameter int          Y_BITS    = 5,
    parameter int          MAX_LEN   = 16,
    parameter int          START_LEN = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic           clk,
    input logic           reset,
    snake_engine_if.slave bus
);
    localparam int LEN_BITS = $clog2(MAX_LEN + 1);
    localparam logic [X_BITS:0]     GW      = (X_BITS + 1)'(GRID_W);
    localparam logic [Y_BITS:0]     GH      = (Y_BITS + 1)'(GRID_H);
    localparam logic [X_BITS:0]     X_ONE   = (X_BITS + 1)'(1);
    localparam logic [Y_BITS:0]     Y_ONE   = (Y_BITS + 1)'(1);
    localparam logic [Y_BITS-1:0]   START_Y = Y_BITS'(GRID_H / 2);
    localparam logic [X_BITS-1:0]   FOOD_X0 = X_BITS'(GRID_W * 3 / 4);
    localparam logic [LEN_BITS-1:0] LEN0    = LEN_BITS'(START_LEN);
    localparam logic [LEN_BITS-1:0] LEN_MAX = LEN_BITS'(MAX_LEN);
    localparam logic [LEN_BITS-1:0] LEN_ONE = LEN_BITS'(1);
`ifdef SNAKE_WRAP_EN
    localparam logic [X_BITS-1:0]   GW_M1   = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0]   GH_M1   = Y_BITS'(GRID_H - 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PLACE, S_OVER} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    state_t              state, state_next;
    dir_t                dir, pending_dir, req_dir;
    logic [X_BITS-1:0]   seg_x [MAX_LEN];
    logic [Y_BITS-1:0]   seg_y [MAX_LEN];
    logic [LEN_BITS-1:0] len;
    logic [X_BITS-1:0]   food_x;
    logic [Y_BITS-1:0]   food_y;
    logic [7:0]          score;
    logic [15:0]         lfsr;
    logic                tick_pend;
    logic [3:0]          btn, btn_prev;
    logic [X_BITS-1:0]   qx_r;
    logic [Y_BITS-1:0]   qy_r;
    logic                q_valid;
    logic                req_ok, go, do_move, do_reinit;
    logic [X_BITS:0]     nx_ext;
    logic [Y_BITS:0]     ny_ext;
    logic [X_BITS-1:0]   nx;
    logic [Y_BITS-1:0]   ny;
    logic                wall, eat, self_hit;
    logic [LEN_BITS-1:0] hit_limit;
    logic [X_BITS-1:0]   cand_x;
    logic [Y_BITS-1:0]   cand_y;
    logic                cand_ok;
    logic                hit_head, hit_body;

    assign btn = {bus.up, bus.down, bus.left, bus.right};
    assign go  = bus.tick || tick_pend;

    always_comb begin
        req_dir = D_RIGHT;
        if (bus.up)        req_dir = D_UP;
        else if (bus.down) req_dir = D_DOWN;
        else if (bus.left) req_dir = D_LEFT;
        // Opposite directions share bit 1 and differ in bit 0.
        req_ok = (|btn) && !((req_dir[1] == dir[1]) && (req_dir[0] != dir[0]));
    end

    always_comb begin
        nx_ext = {1'b0, seg_x[0]};
        ny_ext = {1'b0, seg_y[0]};
        case (pending_dir)
            D_UP:    ny_ext = ny_ext - Y_ONE;
            D_DOWN:  ny_ext = ny_ext + Y_ONE;
            D_LEFT:  nx_ext = nx_ext - X_ONE;
            default: nx_ext = nx_ext + X_ONE;
        endcase
        nx = nx_ext[X_BITS-1:0];
        ny = ny_ext[Y_BITS-1:0];
`ifdef SNAKE_WRAP_EN
        wall = 1'b0;
        if (nx_ext >= GW) nx = (pending_dir == D_LEFT) ? GW_M1 : '0;
        if (ny_ext >= GH) ny = (pending_dir == D_UP) ? GH_M1 : '0;
`else
        wall = (nx_ext >= GW) || (ny_ext >= GH);
`endif
        eat = (nx == food_x) && (ny == food_y);
        // The tail cell frees up during a plain move, but stays occupied while growing.
        hit_limit = eat ? len : len - LEN_ONE;
        self_hit  = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_BITS'(i) < hit_limit) && (seg_x[i] == nx) && (seg_y[i] == ny)) self_hit = 1'b1;
        end
    end

    assign cand_x = lfsr[X_BITS-1:0];
    assign cand_y = lfsr[X_BITS+Y_BITS-1:X_BITS];

    always_comb begin
        cand_ok = ({1'b0, cand_x} < GW) && ({1'b0, cand_y} < GH);
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_BITS'(i) < len) && (seg_x[i] == cand_x) && (seg_y[i] == cand_y)) cand_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_move    = 1'b0;
        do_reinit  = 1'b0;
        case (state)
            S_IDLE: if (req_ok) state_next = S_RUN;
            S_RUN: begin
                if (go) begin
                    if (wall || self_hit) begin
                        state_next = S_OVER;
                    end else begin
                        do_move = 1'b1;
                        if (eat) state_next = S_PLACE;
                    end
                end
            end
            S_PLACE: if (cand_ok) state_next = S_RUN;
            default: begin
                if (|(btn & ~btn_prev)) begin
                    state_next = S_IDLE;
                    do_reinit  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || do_reinit) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= X_BITS'(GRID_W / 2 - i);
                seg_y[i] <= START_Y;
            end
            len         <= LEN0;
            dir         <= D_RIGHT;
            pending_dir <= D_RIGHT;
            score       <= 8'd0;
            food_x      <= FOOD_X0;
            food_y      <= START_Y;
            tick_pend   <= 1'b0;
        end else begin
            if ((state != S_OVER) && req_ok) pending_dir <= req_dir;
            if ((state == S_RUN) && go) begin
                dir       <= pending_dir;
                tick_pend <= 1'b0;
            end
            if (state == S_PLACE) begin
                if (bus.tick) tick_pend <= 1'b1;
                if (cand_ok) begin
                    food_x <= cand_x;
                    food_y <= cand_y;
                end
            end
            if (do_move) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nx;
                seg_y[0] <= ny;
                if (eat) begin
                    if (len < LEN_MAX)  len   <= len + LEN_ONE;
                    if (score != 8'hFF) score <= score + 8'd1;
                end
            end
        end
    end

    // The LFSR survives a restart so successive games get different food sequences.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= LFSR_SEED;
            btn_prev <= '0;
            qx_r     <= '0;
            qy_r     <= '0;
            q_valid  <= 1'b0;
        end else begin
            if (state == S_PLACE) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            btn_prev <= btn;
            qx_r     <= bus.q_x;
            qy_r     <= bus.q_y;
            q_valid  <= 1'b1;
        end
    end

    always_comb begin
        hit_head = (seg_x[0] == qx_r) && (seg_y[0] == qy_r);
        hit_body = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LEN_BITS'(i) < len) && (seg_x[i] == qx_r) && (seg_y[i] == qy_r)) hit_body = 1'b1;
        end
    end

    assign bus.q_head    = q_valid && hit_head;
    assign bus.q_body    = q_valid && hit_body && !hit_head;
    assign bus.q_food    = q_valid && (food_x == qx_r) && (food_y == qy_r);
    assign bus.head_x    = seg_x[0];
    assign bus.head_y    = seg_y[0];
    assign bus.length    = len;
    assign bus.score     = score;
    assign bus.game_over = (state == S_OVER);
    assign bus.dbg_state = state;
endmodule
